// File: rtl/fc_3_argmax.sv
// fc_3_argmax: final classifier stage. Buffers 32 unsigned activations,
// computes OUTPUT_DIM biased class scores serially with a single MAC fed by
// external synchronous-read weight/bias ROMs, and reports the arg-max class.
// Optional feature macro: FC3_SCORE_OUT_EN -- when defined, every class score
// is streamed out on score_wren_o/score_addr_o/score_data_o; otherwise those
// ports are tied to 0.
module fc_3_argmax #(
    parameter int INPUT_DIM  = 32,
    parameter int OUTPUT_DIM = 10,
    parameter int ACT_WIDTH  = 4,
    parameter int W_WIDTH    = 4,
    parameter int BIAS_WIDTH = 8,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         in_wren_i,
    input  logic [4:0]                   in_addr_i,
    input  logic [25:0]                  in_data_i,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [8:0]                   weight_addr_o,
    input  logic signed [W_WIDTH-1:0]    weight_i,
    output logic [3:0]                   bias_addr_o,
    input  logic signed [BIAS_WIDTH-1:0] bias_i,
    output logic [3:0]                   class_o,
    output logic signed [ACC_WIDTH-1:0]  max_score_o,
    output logic                         score_wren_o,
    output logic [3:0]                   score_addr_o,
    output logic signed [ACC_WIDTH-1:0]  score_data_o
);

    localparam int TOTAL  = OUTPUT_DIM * INPUT_DIM;
    localparam int IDX_W  = $clog2(INPUT_DIM);
    localparam int PROD_W = ACT_WIDTH + W_WIDTH + 1;
    localparam logic [8:0]       LAST_K   = 9'(TOTAL - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic                 busy_reg;
    logic                 done_reg;
    logic [1:0]           drain_cnt_reg;
    logic [8:0]           weight_addr_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [3:0]           bias_addr_reg;
    logic                 start_accept;

    // Only the low ACT_WIDTH bits of the upstream data word carry activation.
    logic                 unused_in_bits;
    assign unused_in_bits = ^in_data_i[25:ACT_WIDTH];

    assign start_accept = (state_reg == S_IDLE) && start_i;

    // ------------------------------------------------------------------
    // Activation buffer: one register per activation, frozen while busy
    // ------------------------------------------------------------------
    logic [ACT_WIDTH-1:0] act_reg [INPUT_DIM];

    generate
        for (genvar gi = 0; gi < INPUT_DIM; gi++) begin : g_act
            // Capture upstream writes addressed to this entry when idle.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    act_reg[gi] <= '0;
                end else if (in_wren_i && !busy_reg && (in_addr_i == 5'(gi))) begin
                    act_reg[gi] <= in_data_i[ACT_WIDTH-1:0];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: RUN sweeps all addresses, DRAIN lets the 3 trailing
    // pipeline stages empty, DONE is a single reporting cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start_i) state_next = S_RUN;
            S_RUN:   if (weight_addr_reg == LAST_K) state_next = S_DRAIN;
            S_DRAIN: if (drain_cnt_reg == 2'd2) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Address counters; they hold their last value outside RUN.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            weight_addr_reg <= '0;
            idx_reg         <= '0;
            bias_addr_reg   <= '0;
        end else if (start_accept) begin
            weight_addr_reg <= '0;
            idx_reg         <= '0;
            bias_addr_reg   <= '0;
        end else if ((state_reg == S_RUN) && (weight_addr_reg != LAST_K)) begin
            weight_addr_reg <= weight_addr_reg + 9'd1;
            if (idx_reg == LAST_IDX) begin
                idx_reg       <= '0;
                bias_addr_reg <= bias_addr_reg + 4'd1;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    // Drain counter, busy flag and completion pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drain_cnt_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            drain_cnt_reg <= (state_reg == S_DRAIN) ? drain_cnt_reg + 2'd1 : 2'd0;
            done_reg      <= (state_reg == S_DONE);
            if (start_accept) begin
                busy_reg <= 1'b1;
            end else if (state_reg == S_DONE) begin
                busy_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath pipeline
    // ------------------------------------------------------------------
    logic                        s1_valid_reg, s1_first_reg, s1_last_reg;
    logic [IDX_W-1:0]            s1_idx_reg;
    logic                        s2_valid_reg, s2_first_reg, s2_last_reg;
    logic signed [ACC_WIDTH-1:0] prod_reg;
    logic signed [BIAS_WIDTH-1:0] s2_bias_reg, s3_bias_reg;
    logic                        s3_last_reg;
    logic signed [ACC_WIDTH-1:0] acc_reg;

    logic [ACT_WIDTH-1:0]        act_sel;
    logic signed [PROD_W-1:0]    act_ext, w_ext, prod_full;
    logic signed [ACC_WIDTH-1:0] prod_ext, bias_ext, score;

    // Activation is unsigned: zero-extend it; weight is sign-extended.
    assign act_sel   = act_reg[s1_idx_reg];
    assign act_ext   = {{(PROD_W-ACT_WIDTH){1'b0}}, act_sel};
    assign w_ext     = {{(PROD_W-W_WIDTH){weight_i[W_WIDTH-1]}}, weight_i};
    assign prod_full = act_ext * w_ext;
    assign prod_ext  = {{(ACC_WIDTH-PROD_W){prod_full[PROD_W-1]}}, prod_full};
    assign bias_ext  = {{(ACC_WIDTH-BIAS_WIDTH){s3_bias_reg[BIAS_WIDTH-1]}}, s3_bias_reg};
    assign score     = acc_reg + bias_ext;

    // Stages 1-3: tag the ROM read, multiply, then accumulate per class.
    // The bias is captured alongside the weights because the bias address
    // has already moved on to the next class when the score is formed.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_reg <= 1'b0;
            s1_first_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_idx_reg   <= '0;
            s2_valid_reg <= 1'b0;
            s2_first_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_bias_reg  <= '0;
            prod_reg     <= '0;
            s3_last_reg  <= 1'b0;
            s3_bias_reg  <= '0;
            acc_reg      <= '0;
        end else begin
            s1_valid_reg <= (state_reg == S_RUN);
            s1_first_reg <= (idx_reg == '0);
            s1_last_reg  <= (idx_reg == LAST_IDX);
            s1_idx_reg   <= idx_reg;

            s2_valid_reg <= s1_valid_reg;
            s2_first_reg <= s1_first_reg;
            s2_last_reg  <= s1_last_reg;
            s2_bias_reg  <= bias_i;
            prod_reg     <= prod_ext;

            s3_last_reg  <= s2_valid_reg && s2_last_reg;
            if (start_accept) begin
                acc_reg <= '0;
            end else if (s2_valid_reg) begin
                acc_reg     <= s2_first_reg ? prod_reg : acc_reg + prod_reg;
                s3_bias_reg <= s2_bias_reg;
            end
        end
    end

    logic [3:0]                  class_cnt_reg, best_class_reg, class_reg;
    logic signed [ACC_WIDTH-1:0] best_score_reg, max_score_reg;

    // Stage 4: form the biased score and keep the first strict maximum.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            class_cnt_reg  <= '0;
            best_class_reg <= '0;
            best_score_reg <= '0;
        end else if (start_accept) begin
            class_cnt_reg  <= '0;
            best_class_reg <= '0;
            best_score_reg <= '0;
        end else if (s3_last_reg) begin
            class_cnt_reg <= class_cnt_reg + 4'd1;
            if ((class_cnt_reg == 4'd0) || (score > best_score_reg)) begin
                best_score_reg <= score;
                best_class_reg <= class_cnt_reg;
            end
        end
    end

    // Result registers, published only in the DONE cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            class_reg     <= '0;
            max_score_reg <= '0;
        end else if (state_reg == S_DONE) begin
            class_reg     <= best_class_reg;
            max_score_reg <= best_score_reg;
        end
    end

`ifdef FC3_SCORE_OUT_EN
    logic                        score_wren_reg;
    logic [3:0]                  score_addr_reg;
    logic signed [ACC_WIDTH-1:0] score_data_reg;

    // Stream each class score out as it is formed.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            score_wren_reg <= 1'b0;
            score_addr_reg <= '0;
            score_data_reg <= '0;
        end else begin
            score_wren_reg <= s3_last_reg;
            if (s3_last_reg) begin
                score_addr_reg <= class_cnt_reg;
                score_data_reg <= score;
            end
        end
    end

    assign score_wren_o = score_wren_reg;
    assign score_addr_o = score_addr_reg;
    assign score_data_o = score_data_reg;
`else
    assign score_wren_o = 1'b0;
    assign score_addr_o = '0;
    assign score_data_o = '0;
`endif

    assign busy_o        = busy_reg;
    assign done_o        = done_reg;
    assign weight_addr_o = weight_addr_reg;
    assign bias_addr_o   = bias_addr_reg;
    assign class_o       = class_reg;
    assign max_score_o   = max_score_reg;

endmodule

// File: doc/fc_3_argmax.md
# fc_3_argmax

Final classifier stage, directly downstream of the second fully-connected layer. Captures the 32 quantised 4-bit activations from the upstream layer's output write port into a local register buffer. On `start_i` it computes 10 class scores serially with one MAC: weights come from an external synchronous-read ROM, plus an 8-bit bias per class. It then reports the arg-max class index and its score.

## Interface
**Parameters**
- `INPUT_DIM`, 32: activations per class.
- `OUTPUT_DIM`, 10: number of classes.
- `ACT_WIDTH`, 4: unsigned activation width.
- `W_WIDTH`, 4: signed weight width.
- `BIAS_WIDTH`, 8: signed bias width.
- `ACC_WIDTH`, 16: signed accumulator and score width.

**Ports**
- `clk_i`, in, 1: clock.
- `rst_n_i`, in, 1: reset; asynchronous, active-low.
- `in_wren_i`, in, 1: activation write enable (upstream `fc_output_wren_o`).
- `in_addr_i`, in, 5: activation index.
- `in_data_i`, in, 26: activation data. Only bits `[ACT_WIDTH-1:0]` are used; the rest are ignored.
- `start_i`, in, 1: start classification.
- `busy_o`, out, 1: high from the cycle after start is accepted until `done_o`.
- `done_o`, out, 1: one-cycle completion pulse.
- `weight_addr_o`, out, 9: weight ROM address, equal to `class*INPUT_DIM + idx`.
- `weight_i`, in, `W_WIDTH`: signed weight. Valid one cycle after its address.
- `bias_addr_o`, out, 4: bias ROM address, equal to the class.
- `bias_i`, in, `BIAS_WIDTH`: signed bias. Valid one cycle after its address.
- `class_o`, out, 4: winning class. Holds until the next `done_o`.
- `max_score_o`, out, `ACC_WIDTH`: winning score, signed.
- `score_wren_o`, out, 1: per-class score write strobe (see Configuration).
- `score_addr_o`, out, 4: per-class score address.
- `score_data_o`, out, `ACC_WIDTH`: per-class score data.

## Operation
**Reset**
- All outputs are 0 on reset.
- The activation buffer, counters, accumulator and best-score registers are cleared.
- The state machine returns to IDLE.

**Activation buffer**
- 32 × `ACT_WIDTH` registers.
- Written on `in_wren_i` only while `busy_o`=0.
- Writes while busy are dropped.

**States**
- IDLE: on `start_i`, go to RUN and clear the counter and accumulator. A `start_i` outside IDLE is ignored.
- RUN: sweep k = 0..`OUTPUT_DIM*INPUT_DIM`-1, one per cycle.
  - `weight_addr_o` = k.
  - `bias_addr_o` = k / `INPUT_DIM`.
  - After k = 319, go to DRAIN.
- DRAIN: 3 cycles for the pipeline to empty, then go to DONE.
- DONE: one cycle. Pulse `done_o`, update `class_o`/`max_score_o`, then go to IDLE.

**Datapath pipeline**
- Stage 1: ROM read.
- Stage 2: product = act[idx] (zero-extended) × `weight_i` (signed), registered.
- Stage 3: accumulate, with the accumulator reset at each class boundary.
- Stage 4: score = acc + sign-extended bias, then compare against best.

**Arithmetic**
- Product range is -120..105.
- Class sum range is ±3840; with bias, ±3968, which fits 14 bits.
- All values are sign-extended to `ACC_WIDTH`. No saturation.

**Arg-max rule**
- Class 0 unconditionally initialises best.
- A later class replaces best only if its score is strictly greater, so ties keep the lowest index.

**Reset mid-operation**: immediate abort to IDLE. No `done_o` is produced and `class_o` returns to 0.

## Timing
- Edge 0 is the rising edge that samples `start_i` in IDLE.
- In the cycle after edge k (k = 0..319), `weight_addr_o` = k.
- The score of class c is formed at edge 32c+35.
- `done_o`, `class_o` and `max_score_o` update at edge 324, i.e. `OUTPUT_DIM*INPUT_DIM`+4.
- `busy_o` is high after edges 0..323 and low after edge 324.
- Back-to-back starts: `start_i` is accepted at the earliest at the edge after the `done_o` cycle.
- The address outputs hold their last value outside RUN.

## Configuration
- `FC3_SCORE_OUT_EN` defined:
  - `score_wren_o` pulses one cycle per class, asserted after edge 32c+35.
  - `score_addr_o` = c and `score_data_o` = that class's biased score.
  - Scores therefore write to addresses 0..9 in order, the last one coinciding with the cycle before `done_o`.
- `FC3_SCORE_OUT_EN` undefined: the score port logic is removed and `score_wren_o`/`score_addr_o`/`score_data_o` are tied to 0.

## Test plan
- **Reset**: assert `rst_n_i`=0 with random inputs → every output is 0, `busy_o`=0.
- **Single winner**: all acts 1; weights 0 except class 3 all +1; biases 0 → `done_o` at edge 324, `class_o`=3, `max_score_o`=32.
- **Tie**: all weights 0, all biases +5 → `class_o`=0, `max_score_o`=5.
- **Negative extremes**: acts 15, weights -8, biases -128 except class 7 bias 0 → `class_o`=7, `max_score_o`=-3840 (0xF100).
- **Ignored writes and starts**: during RUN, write act[0]=15 and pulse `start_i` → result identical to the undisturbed run; exactly one `done_o`.
- **Reset mid-RUN**: reset at edge 100, then restart → no spurious `done_o`; result equals a clean run after the buffer is reloaded.
- **Score port**: with `FC3_SCORE_OUT_EN` defined, the single-winner case gives 10 strobes, addresses 0..9, data 0,0,0,32,0,…
